// File: rtl/panda_pkg.sv
// Shared types for the panda iterative divider: operation encoding, FSM states
// and small operation-decode helpers.
package panda_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic is_rem_op(input div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

    function automatic logic is_signed_op(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/panda_adder.sv
// Generic adder/subtractor; subtraction is done as a + ~b + 1.
module panda_adder #(
    parameter int Width = 33
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             subtract_i,
    output logic [Width-1:0] sum_o
);

    logic [Width-1:0] b_eff;

    assign b_eff = subtract_i ? ~b_i : b_i;
    assign sum_o = a_i + b_eff + {{(Width-1){1'b0}}, subtract_i};

endmodule

// File: rtl/panda_divider.sv
// Iterative restoring divider (RISC-V M DIV/DIVU/REM/REMU), one quotient bit per
// cycle, with fast paths for divide-by-zero and signed overflow.
module panda_divider
    import panda_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  div_op_e          operator_i,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] result_o
);

    localparam int CntW = $clog2(Width) + 1;
    localparam logic [CntW-1:0] LastStep = CntW'(Width - 1);

    div_state_e       state_q;
    div_op_e          op_q;
    logic [Width-1:0] dvd_q;
    logic [Width-1:0] dsr_q;
    logic [Width-1:0] rem_q;
    logic [Width-1:0] result_q;
    logic [CntW-1:0]  cnt_q;
    logic             neg_q;
    logic             ready_q;
    logic             valid_q;

    logic                    sgn_op, sign_a, sign_b, div_zero, sgn_ovf;
    logic signed [Width:0]   neg_a, neg_b, trial, fix;
    logic [Width-1:0]        mag_a, mag_b;
    logic [Width:0]          rem_shift;
    logic                    step_ok;
    logic [Width-1:0]        rem_next, quot_next, final_mag, final_res;
    logic                    unused_msbs;

    // Acceptance: magnitudes of signed operands and fast-path detection
    assign sgn_op   = is_signed_op(operator_i);
    assign sign_a   = sgn_op & operand_a_i[Width-1];
    assign sign_b   = sgn_op & operand_b_i[Width-1];
    assign div_zero = (operand_b_i == '0);
    assign sgn_ovf  = sgn_op && (operand_a_i == {1'b1, {(Width-1){1'b0}}}) && (operand_b_i == '1);

    panda_adder #(.Width(Width+1)) u_neg_a (
        .a_i({(Width+1){1'b0}}), .b_i({1'b0, operand_a_i}), .subtract_i(1'b1), .sum_o(neg_a)
    );
    panda_adder #(.Width(Width+1)) u_neg_b (
        .a_i({(Width+1){1'b0}}), .b_i({1'b0, operand_b_i}), .subtract_i(1'b1), .sum_o(neg_b)
    );

    assign mag_a = sign_a ? neg_a[Width-1:0] : operand_a_i;
    assign mag_b = sign_b ? neg_b[Width-1:0] : operand_b_i;

    // Iteration: quotient bits shift into the vacated LSBs of the dividend register
    assign rem_shift = {rem_q, dvd_q[Width-1]};

    panda_adder #(.Width(Width+1)) u_trial (
        .a_i(rem_shift), .b_i({1'b0, dsr_q}), .subtract_i(1'b1), .sum_o(trial)
    );

    assign step_ok   = ~trial[Width];
    assign rem_next  = step_ok ? trial[Width-1:0] : rem_shift[Width-1:0];
    assign quot_next = {dvd_q[Width-2:0], step_ok};
    assign final_mag = is_rem_op(op_q) ? rem_next : quot_next;

    // Completion: sign correction folded into the last step
    panda_adder #(.Width(Width+1)) u_fix (
        .a_i({(Width+1){1'b0}}), .b_i({1'b0, final_mag}), .subtract_i(1'b1), .sum_o(fix)
    );

    assign final_res   = neg_q ? fix[Width-1:0] : final_mag;
    assign unused_msbs = ^{neg_a[Width], neg_b[Width], fix[Width]};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= DIVU;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        op_q    <= operator_i;
                        ready_q <= 1'b0;
                        if (div_zero) begin
                            result_q <= is_rem_op(operator_i) ? operand_a_i : '1;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else if (sgn_ovf) begin
                            result_q <= is_rem_op(operator_i) ? '0 : operand_a_i;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            dvd_q   <= mag_a;
                            dsr_q   <= mag_b;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            neg_q   <= is_rem_op(operator_i) ? sign_a : (sign_a ^ sign_b);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    dvd_q <= quot_next;
                    rem_q <= rem_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastStep) begin
                        result_q <= final_res;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule
